// File: rtl/lifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_pkg
//  Description : Shared definitions for the LIFO and its drain engine.
//                Default data width, stack depth, drain FSM state
//                encoding and the stack word type.
//  Revision    : 1.0  initial release
// ============================================================================
package lifo_pkg;

   localparam int DW         = 8;
   localparam int LIFO_DEPTH = 8;

   // Drain FSM states, explicitly 2 bits wide.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   typedef logic [DW-1:0] word_t;

endpackage : lifo_pkg
`default_nettype wire

// File: rtl/lifo_drain.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_drain
//  Description : Pops words from an 8-deep LIFO on a start request and
//                presents each one on a valid/ready stream. The last word
//                of a burst is tagged with m_last. A burst ends when the
//                stack runs empty or MAX_BURST words have been handed off.
//
//  Ports       : clk, reset_n        clock, async active-low reset
//                start               drain request (sampled in IDLE only)
//                lifo_empty/lifo_wn  LIFO status / observed write strobe
//                lifo_dataout        popped word, valid the cycle after pop
//                lifo_rn             pop strobe to the LIFO
//                m_data/m_valid/     output stream
//                m_ready/m_last
//                busy                high whenever not IDLE
//                burst_count         words handed off in current/last burst
//                m_parity            (LIFO_DRAIN_PARITY_EN only) XOR of word
//
//  Options     : define LIFO_DRAIN_PARITY_EN to add the m_parity output.
//  Revision    : 1.0  initial release
// ============================================================================
module lifo_drain #(
   parameter int DW        = 8,
   parameter int MAX_BURST = 8,
   parameter int CW        = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          lifo_empty,
   input  logic          lifo_wn,
   input  logic [DW-1:0] lifo_dataout,
   output logic          lifo_rn,
   output logic [DW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_last,
   output logic          busy,
   output logic [CW-1:0] burst_count
`ifdef LIFO_DRAIN_PARITY_EN
   ,
   output logic          m_parity
`endif
);

   import lifo_pkg::*;

   localparam logic [CW-1:0] C_MAX_BURST = CW'(MAX_BURST);

   state_t        state_q, state_d;
   logic [DW-1:0] m_data_q, m_data_d;
   logic          m_valid_q, m_valid_d;
   logic          m_last_q, m_last_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          w_handshake;
   logic [CW-1:0] w_cnt_inc;

   assign w_handshake = m_valid_q & m_ready;
   assign w_cnt_inc   = cnt_q + CW'(1);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start && !lifo_empty) state_d = POP;
         // A concurrent write wins inside the LIFO, so the pop is retried.
         POP:  if (!lifo_wn)             state_d = WAIT;
         WAIT:                           state_d = HOLD;
         HOLD: if (w_handshake)          state_d = m_last_q ? IDLE : POP;
         default:                        state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output / datapath next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start && !lifo_empty) cnt_d = '0;
         end
         WAIT: begin
            // lifo_empty already reflects the pointer after this pop.
            m_data_d  = lifo_dataout;
            m_valid_d = 1'b1;
            m_last_d  = lifo_empty | (w_cnt_inc == C_MAX_BURST);
         end
         HOLD: begin
            if (w_handshake) begin
               cnt_d     = w_cnt_inc;
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         cnt_q     <= cnt_d;
      end
   end

   assign lifo_rn     = (state_q == POP);
   assign busy        = (state_q != IDLE);
   assign m_data      = m_data_q;
   assign m_valid     = m_valid_q;
   assign m_last      = m_last_q;
   assign burst_count = cnt_q;

`ifdef LIFO_DRAIN_PARITY_EN
   logic m_parity_q, m_parity_d;

   always_comb begin
      m_parity_d = m_parity_q;
      if (state_q == WAIT) m_parity_d = ^lifo_dataout;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_parity_q <= 1'b0;
      end else begin
         m_parity_q <= m_parity_d;
      end
   end

   assign m_parity = m_parity_q;
`endif

endmodule : lifo_drain
`default_nettype wire

// File: tb/tb_lifo_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lifo_drain
//  Description : Self-checking bench for lifo_drain. Contains a behavioural
//                8-deep LIFO and a queue-based scoreboard of pushed words.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lifo_drain;

   localparam int DW = 8;
   localparam int MB = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          lifo_wn = 1'b0;
   logic [DW-1:0] lifo_din = '0;
   logic          m_ready = 1'b0;
   logic          lifo_empty = 1'b1;
   logic [DW-1:0] lifo_dataout = '0;
   logic          lifo_rn;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_last;
   logic          busy;
   logic [CW-1:0] burst_count;
`ifdef LIFO_DRAIN_PARITY_EN
   logic          m_parity;
`endif

   always #5 clk = ~clk;

   lifo_drain #(.DW(DW), .MAX_BURST(MB), .CW(CW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .lifo_empty(lifo_empty), .lifo_wn(lifo_wn), .lifo_dataout(lifo_dataout),
      .lifo_rn(lifo_rn), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .busy(busy), .burst_count(burst_count)
`ifdef LIFO_DRAIN_PARITY_EN
      , .m_parity(m_parity)
`endif
   );

   // ---------------- behavioural LIFO (environment) -----------------
   logic [DW-1:0] lq[$];
   int pop_cnt = 0;
   int rn_cycles = 0;

   always @(posedge clk) begin
      if (lifo_rn) rn_cycles++;
      if (lifo_wn) begin
         if (lq.size() < 8) lq.push_back(lifo_din);
      end else if (lifo_rn && lq.size() > 0) begin
         lifo_dataout <= lq.pop_back();
         pop_cnt++;
      end
      lifo_empty <= (lq.size() == 0);
   end

   // ---------------- scoreboard -----------------
   int checks = 0;
   int failures = 0;
   logic [DW-1:0] ref_stk[$];
   logic [DW-1:0] got_d[$];
   logic          got_l[$];
   logic          got_p[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [DW-1:0] d);
      @(negedge clk);
      lifo_wn  = 1'b1;
      lifo_din = d;
      if (ref_stk.size() < 8) ref_stk.push_back(d);
      @(negedge clk);
      lifo_wn  = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits (m_ready low) until m_valid rises; returns negedges waited.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!m_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!m_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
   endtask

   // Accept words with a ready pattern until one tagged last is taken.
   task automatic collect(input int gap);
      int  cyc = 0;
      bit  done = 0;
      got_d.delete(); got_l.delete(); got_p.delete();
      while (!done && cyc < 400) begin
         @(negedge clk);
         m_ready = (gap == 0) ? 1'b1 : ((cyc % (gap + 1)) == gap);
         if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
`ifdef LIFO_DRAIN_PARITY_EN
            got_p.push_back(m_parity);
`endif
            if (m_last) done = 1;
         end
         cyc++;
      end
      if (!done) chk("collect_timeout", 32'd0, 32'd1);
      @(negedge clk);
      m_ready = 1'b0;
   endtask

   // Expected burst: newest-first from the scoreboard, at most MB words.
   task automatic check_burst(input string tag);
      int n;
      logic [DW-1:0] e;
      n = (ref_stk.size() < MB) ? ref_stk.size() : MB;
      chk({tag, "_count"}, got_d.size(), n);
      for (int i = 0; i < n; i++) begin
         e = ref_stk.pop_back();
         if (i < got_d.size()) begin
            chk({tag, "_data"}, got_d[i], e);
            chk({tag, "_last"}, got_l[i], (i == n - 1));
         end
      end
      chk({tag, "_burst_count"}, burst_count, n);
      chk({tag, "_busy_after"}, busy, 1'b0);
   endtask

   typedef struct {
      int            npush;
      logic [DW-1:0] base;
      logic [DW-1:0] step;
      int            gap;
      int            exp_n;
      logic [DW-1:0] exp_first;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int lat, rn0, pop0, stable;
      logic [DW-1:0] first;
      logic lasts_ok;

      tbl[0] = '{3, 8'h11, 8'h11, 0, 3, 8'h33};
      tbl[1] = '{1, 8'h5A, 8'h00, 2, 1, 8'h5A};
      tbl[2] = '{8, 8'hF0, 8'h01, 1, 8, 8'hF7};
      tbl[3] = '{5, 8'h00, 8'h40, 3, 5, 8'h00};

      // ---- reset state ----
      repeat (3) @(negedge clk);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_lifo_rn", lifo_rn, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_burst_count", burst_count, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 1'b0);
      reset_n = 1'b1;

      // ---- table-driven bursts ----
      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < tbl[t].npush; k++)
            push(tbl[t].base + DW'(k) * tbl[t].step);
         pulse_start();
         collect(tbl[t].gap);
         if (got_d.size() > 0) chk("tbl_first", got_d[0], tbl[t].exp_first);
         chk("tbl_n", got_d.size(), tbl[t].exp_n);
         check_burst("tbl");
      end

      // ---- start with empty LIFO is ignored ----
      rn0 = rn_cycles;
      pulse_start();
      repeat (4) @(negedge clk);
      chk("empty_busy", busy, 1'b0);
      chk("empty_m_valid", m_valid, 1'b0);
      chk("empty_rn", rn_cycles - rn0, 0);
      chk("empty_burst_count_kept", burst_count, 5);

      // ---- single word, sink stalled 10 cycles ----
      push(8'hA5);
      rn0 = rn_cycles;
      pulse_start();
      wait_valid(lat);
      chk("latency", lat, 2);
      stable = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (m_valid && m_data == 8'hA5 && m_last) stable++;
      end
      chk("stall_stable", stable, 10);
      chk("stall_rn_once", rn_cycles - rn0, 1);
      collect(0);
      check_burst("stall");

      // ---- writer collides with POP on a full LIFO ----
      for (int k = 0; k < 8; k++) push(8'h41 + DW'(k));
      rn0 = rn_cycles; pop0 = pop_cnt;
      pulse_start();
      lifo_wn = 1'b1; lifo_din = 8'hEE;
      repeat (2) @(negedge clk);
      lifo_wn = 1'b0;
      wait_valid(lat);
      chk("wn_rn_cycles", rn_cycles - rn0, 3);
      chk("wn_pops", pop_cnt - pop0, 1);
      collect(0);
      check_burst("wn");

      // ---- MAX_BURST cap with a push during the burst ----
      for (int k = 0; k < 8; k++) push(8'h81 + DW'(k));
      pulse_start();
      wait_valid(lat);
      first = ref_stk.pop_back();
      push(8'h99);
      collect(0);
      chk("mb_count", got_d.size(), 8);
      if (got_d.size() == 8) begin
         chk("mb_first", got_d[0], first);
         lasts_ok = 1'b1;
         for (int i = 1; i < 8; i++) begin
            chk("mb_data", got_d[i], ref_stk.pop_back());
            if (got_l[i-1]) lasts_ok = 1'b0;
         end
         chk("mb_last", {lasts_ok, got_l[7]}, 2'b11);
      end
      chk("mb_burst_count", burst_count, 8);
      chk("mb_leftover", ref_stk.size(), 1);
      pulse_start();
      collect(0);
      check_burst("mb_second");

`ifdef LIFO_DRAIN_PARITY_EN
      // ---- parity ----
      push(8'h03);
      push(8'h07);
      pulse_start();
      collect(0);
      chk("par_n", got_p.size(), 2);
      if (got_p.size() == 2) begin
         chk("par0", got_p[0], 1'b1);
         chk("par1", got_p[1], 1'b0);
      end
      check_burst("par");
`endif

      // ---- randomized bursts ----
      for (int r = 0; r < 6; r++) begin
         int n = $urandom_range(1, 8);
         for (int k = 0; k < n; k++) push(DW'($urandom));
         pulse_start();
         collect($urandom_range(0, 3));
         check_burst("rand");
      end

      // ---- asynchronous reset during HOLD ----
      push(8'h3C);
      push(8'h4D);
      pulse_start();
      wait_valid(lat);
      void'(ref_stk.pop_back());
      #2 reset_n = 1'b0;
      #1;
      chk("arst_m_valid", m_valid, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_burst_count", burst_count, 0);
      @(negedge clk);
      reset_n = 1'b1;
      pulse_start();
      collect(0);
      check_burst("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global guard so the bench always terminates.
   initial begin
      #2000000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule : tb_lifo_drain
`default_nettype wire
